// File: rtl/multicycle_mem_responder_if.sv
// Request/response bus between the multicycle datapath and its unified memory responder.
// master = datapath side, slave = memory responder side.
interface multicycle_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/multicycle_mem_responder.sv
// Unified instruction/data word memory with programmable wait states and a req/ready handshake.
module multicycle_mem_responder #(
    parameter int ADDR_W    = 8,
    parameter int WAIT_CYC  = 2,
    parameter     INIT_FILE = "program.hex"
) (
    input  logic                          clk,
    input  logic                          rst_n,
    multicycle_mem_responder_if.slave     bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        take;
    logic        access;

    logic        we_lat;
    logic [31:0] addr_lat;
    logic [31:0] wdata_lat;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        reject;
    logic [ADDR_W-1:0] idx;

    logic [31:0] rdata_q;
    logic        ready_q;
    logic        err_q;
    logic        busy_q;

    logic [31:0] mem [DEPTH];

    // Zero-wait builds perform the access on the sampling edge, so bypass the latches in IDLE.
    assign acc_we    = (state == ST_IDLE) ? bus.we    : we_lat;
    assign acc_addr  = (state == ST_IDLE) ? bus.addr  : addr_lat;
    assign acc_wdata = (state == ST_IDLE) ? bus.wdata : wdata_lat;

    assign reject = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);
    assign idx    = acc_addr[ADDR_W+1:2];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        access    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    take = 1'b1;
                    if (WAIT_CYC == 0) begin
                        state_nxt = ST_RESP;
                        access    = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                    access    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ready_q <= (state_nxt == ST_RESP);
            err_q   <= access && reject;
            busy_q  <= (state_nxt != ST_IDLE);
            if (access && !reject && !acc_we) begin
                rdata_q <= mem[idx];
            end
        end
    end

    // Request copies are data only; they need no reset because state gates their use.
    always_ff @(posedge clk) begin
        if (take) begin
            we_lat    <= bus.we;
            addr_lat  <= bus.addr;
            wdata_lat <= bus.wdata;
        end
    end

    // rst_n gate keeps a zero-wait IDLE access from committing while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && access && !reject && acc_we) begin
            mem[idx] <= acc_wdata;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

endmodule
